// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes the SPI command/address/data byte stream into memory requests
// and answers with read data or status through the shifter's transmit byte.
module spi_cmd_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_load,
    output logic [7:0]        tx_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WDATA, S_RDATA, S_STAT, S_IGNORE
    } state_t;
    state_t      r_state;
    logic        r_cs_m, r_cs_s, r_rd, r_under, r_over, r_full;
    logic [7:0]  r_hi, r_buf;
    logic [15:0] w_addr16;
    logic [7:0]  w_status;
    assign w_addr16 = {r_hi, rx_data};
    assign w_status = {5'b0, r_under, r_over, mem_req};
    assign busy     = (r_state != S_IDLE) | mem_req;
    // mem_addr doubles as the transfer address counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cs_m    <= 1'b1;
            r_cs_s    <= 1'b1;
            r_rd      <= 1'b0;
            r_under   <= 1'b0;
            r_over    <= 1'b0;
            r_full    <= 1'b0;
            r_hi      <= 8'h00;
            r_buf     <= 8'h00;
            tx_data   <= 8'h00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            r_cs_m <= spi_cs;
            r_cs_s <= r_cs_m;
            if (mem_req && mem_ack) begin
                mem_req <= 1'b0;
                if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
                else if (r_state == S_RDATA) begin
                    r_buf  <= mem_rdata;
                    r_full <= 1'b1;
                end
            end
            // a deselected bus aborts the transaction; an outstanding request still completes
            if (r_cs_s) r_state <= S_IDLE;
            else case (r_state)
                S_IDLE: if (!mem_req) begin
                    r_state <= S_CMD;
                    tx_data <= 8'h00;
                    r_full  <= 1'b0;
                end
                S_CMD: begin
                    if (tx_load) tx_data <= w_status;
                    if (rx_valid) begin
                        r_rd    <= rx_data == 8'h02;
                        r_state <= (rx_data == 8'h01 || rx_data == 8'h02) ? S_ADDR_HI :
                                   (rx_data == 8'h03) ? S_STAT : S_IGNORE;
                        if (rx_data == 8'h03) begin
                            r_under <= 1'b0;
                            r_over  <= 1'b0;
                        end
                    end
                end
                S_ADDR_HI: if (rx_valid) begin
                    r_hi    <= rx_data;
                    r_state <= S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    if (tx_load && r_rd) tx_data <= 8'h00;
                    if (rx_valid) begin
                        mem_addr <= w_addr16[ADDR_W-1:0];
                        r_state  <= r_rd ? S_RDATA : S_WDATA;
                        if (r_rd) begin
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end
                    end
                end
                S_WDATA: if (rx_valid) begin
                    if (mem_req) r_over <= 1'b1;
                    else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= rx_data;
                    end
                end
                S_RDATA: if (tx_load) begin
                    if (r_full) begin
                        tx_data  <= r_buf;
                        r_full   <= 1'b0;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                    end else begin
                        tx_data <= 8'hEE;
                        r_under <= 1'b1;
                    end
                end
                S_STAT: if (tx_load) tx_data <= w_status;
                S_IGNORE: if (tx_load) tx_data <= 8'hFF;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: drives SPI byte slots and a latency-controlled memory, comparing
// against expectations computed from the protocol rules.
module tb_spi_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rst, spi_cs, rx_valid, tx_load, mem_ack;
    logic [7:0]  rx_data, mem_rdata, tx_data, mem_wdata;
    logic        mem_req, mem_we, busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_m [0:65535];
    logic [15:0] wa_q[$], ra_q[$];
    logic [7:0]  wd_q[$];
    int          ack_lat = 2;
    bit          hold_ack = 1'b0;
    int          req_cycles = 0;
    int          checks = 0, passes = 0;

    spi_cmd_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .spi_cs(spi_cs), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_load(tx_load), .tx_data(tx_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory: acks ack_lat cycles after seeing a request, unless held
    initial begin
        int wcnt;
        wcnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem_m[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (mem_ack) mem_ack = 1'b0;
            else if (!mem_req || hold_ack) wcnt = 0;
            else if (wcnt >= ack_lat) begin
                mem_ack = 1'b1;
                wcnt = 0;
                if (mem_we) begin
                    mem_m[mem_addr] = mem_wdata;
                    wa_q.push_back(mem_addr);
                    wd_q.push_back(mem_wdata);
                end else begin
                    mem_rdata = mem_m[mem_addr];
                    ra_q.push_back(mem_addr);
                end
            end else wcnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // one byte slot: tx_load first (loads next slot), then the received byte
    task automatic xfer(input logic [7:0] b, output logic [7:0] tx);
        @(negedge clk) tx_load = 1'b1;
        @(negedge clk) tx_load = 1'b0;
        @(negedge clk) tx = tx_data;
        @(negedge clk) begin rx_data = b; rx_valid = 1'b1; end
        @(negedge clk) rx_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic begin_txn();
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_txn();
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL end_txn busy: got %b expected 0", busy);
        else passes++;
    endtask

    task automatic status_txn(output logic [7:0] r1, output logic [7:0] r2);
        logic [7:0] t;
        begin_txn();
        xfer(8'h03, r1);
        xfer(8'h00, r2);
        xfer(8'h00, t);
        end_txn();
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_cs = 1'b1; rx_valid = 1'b0; tx_load = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h expected 00", tx_data);
        else passes++;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, busy} !== 27'd0)
            $display("FAIL reset outputs: got req=%b we=%b addr=%h wdata=%h busy=%b expected all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, busy);
        else passes++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_fixed();
        logic [7:0] tx, r1, r2;
        ack_lat = 3;
        wa_q.delete(); wd_q.delete();
        begin_txn();
        xfer(8'h01, tx); xfer(8'h12, tx); xfer(8'h34, tx); xfer(8'hAA, tx); xfer(8'hBB, tx);
        end_txn();
        checks++;
        if (wa_q.size() !== 2) $display("FAIL write_fixed count: got %0d expected 2", wa_q.size());
        else passes++;
        if (wa_q.size() == 2) begin
            checks++;
            if ({wa_q[0], wd_q[0], wa_q[1], wd_q[1]} !== {16'h1234, 8'hAA, 16'h1235, 8'hBB})
                $display("FAIL write_fixed data: got %h/%h %h/%h expected 1234/aa 1235/bb",
                         wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
            else passes++;
        end
        status_txn(r1, r2);
        checks++;
        if (r1 !== 8'h00) $display("FAIL write_fixed status: got %h expected 00", r1);
        else passes++;
    endtask

    task automatic test_read_wrap();
        logic [7:0] c[6];
        ack_lat = 2;
        mem_m[16'hFFFF] = 8'h5A; mem_m[16'h0000] = 8'h5B;
        ra_q.delete();
        begin_txn();
        xfer(8'h02, c[0]); xfer(8'hFF, c[1]); xfer(8'hFF, c[2]);
        xfer(8'h00, c[3]); xfer(8'h00, c[4]); xfer(8'h00, c[5]);
        end_txn();
        checks++;
        if ({c[2], c[3], c[4]} !== 24'h005A5B)
            $display("FAIL read_wrap tx: got %h %h %h expected 00 5a 5b", c[2], c[3], c[4]);
        else passes++;
        checks++;
        if (ra_q.size() < 2 || ra_q[0] !== 16'hFFFF || ra_q[1] !== 16'h0000)
            $display("FAIL read_wrap addr: got %0d reads first=%h expected ffff then 0000",
                     ra_q.size(), ra_q.size() > 0 ? ra_q[0] : 16'h0);
        else passes++;
    endtask

    task automatic test_random_rw();
        logic [7:0]  tx;
        logic [7:0]  d[$];
        logic [15:0] a;
        int          n;
        for (int t = 0; t < 6; t++) begin
            a = 16'($urandom);
            if (t == 0) a = 16'hFFFE;
            n = $urandom_range(1, 4);
            ack_lat = $urandom_range(0, 4);
            d.delete();
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            wa_q.delete(); wd_q.delete(); ra_q.delete();
            begin_txn();
            xfer(8'h01, tx); xfer(a[15:8], tx); xfer(a[7:0], tx);
            foreach (d[i]) xfer(d[i], tx);
            end_txn();
            checks++;
            if (wa_q.size() !== n) $display("FAIL rand_write count: got %0d expected %0d", wa_q.size(), n);
            else passes++;
            for (int i = 0; i < n && i < wa_q.size(); i++) begin
                checks++;
                if (wa_q[i] !== 16'(a + i) || wd_q[i] !== d[i])
                    $display("FAIL rand_write %0d: got %h/%h expected %h/%h", i, wa_q[i], wd_q[i], 16'(a + i), d[i]);
                else passes++;
            end
            begin_txn();
            xfer(8'h02, tx); xfer(a[15:8], tx); xfer(a[7:0], tx);
            checks++;
            if (tx !== 8'h00) $display("FAIL rand_read dummy: got %h expected 00", tx);
            else passes++;
            for (int i = 0; i < n; i++) begin
                xfer(8'($urandom), tx);
                checks++;
                if (tx !== d[i]) $display("FAIL rand_read %0d: got %h expected %h", i, tx, d[i]);
                else passes++;
            end
            end_txn();
            for (int i = 0; i < n; i++) begin
                checks++;
                if (i >= ra_q.size() || ra_q[i] !== 16'(a + i))
                    $display("FAIL rand_read addr %0d: got %h expected %h", i, i < ra_q.size() ? ra_q[i] : 16'h0, 16'(a + i));
                else passes++;
            end
        end
    endtask

    task automatic test_underrun();
        logic [7:0]  c[5];
        logic [7:0]  v, r1, r2;
        logic [15:0] a;
        a = 16'($urandom_range(0, 16'hFFFE));
        v = 8'($urandom);
        mem_m[a] = v;
        ack_lat = 30;
        ra_q.delete();
        begin_txn();
        xfer(8'h02, c[0]); xfer(a[15:8], c[1]); xfer(a[7:0], c[2]); xfer(8'h00, c[3]);
        repeat (40) @(negedge clk);
        ack_lat = 2;
        xfer(8'h00, c[4]);
        end_txn();
        checks++;
        if ({c[2], c[3], c[4]} !== {8'h00, 8'hEE, v})
            $display("FAIL underrun tx: got %h %h %h expected 00 ee %h", c[2], c[3], c[4], v);
        else passes++;
        checks++;
        if (ra_q.size() < 2 || ra_q[0] !== a || ra_q[1] !== 16'(a + 1))
            $display("FAIL underrun addr: got %0d reads expected %h then %h", ra_q.size(), a, 16'(a + 1));
        else passes++;
        status_txn(r1, r2);
        checks++;
        if ({r1, r2} !== 16'h0400) $display("FAIL underrun status: got %h %h expected 04 00", r1, r2);
        else passes++;
        status_txn(r1, r2);
        checks++;
        if (r1 !== 8'h00) $display("FAIL underrun status_clear: got %h expected 00", r1);
        else passes++;
    endtask

    task automatic test_overrun();
        logic [7:0]  tx, d1, r1, r2;
        logic [15:0] a;
        a = 16'($urandom);
        d1 = 8'($urandom);
        ack_lat = 0;
        hold_ack = 1'b1;
        wa_q.delete(); wd_q.delete();
        begin_txn();
        xfer(8'h01, tx); xfer(a[15:8], tx); xfer(a[7:0], tx); xfer(d1, tx); xfer(~d1, tx);
        checks++;
        if (mem_req !== 1'b1) $display("FAIL overrun req_held: got %b expected 1", mem_req);
        else passes++;
        hold_ack = 1'b0;
        end_txn();
        checks++;
        if (wa_q.size() !== 1 || wa_q[0] !== a || wd_q[0] !== d1)
            $display("FAIL overrun writes: got %0d writes expected one %h/%h", wa_q.size(), a, d1);
        else passes++;
        status_txn(r1, r2);
        checks++;
        if (r1 !== 8'h02) $display("FAIL overrun status: got %h expected 02", r1);
        else passes++;
        status_txn(r1, r2);
        checks++;
        if (r1 !== 8'h00) $display("FAIL overrun status_clear: got %h expected 00", r1);
        else passes++;
    endtask

    task automatic test_ignore();
        logic [7:0] c[3];
        int rc;
        ack_lat = 0;
        rc = req_cycles;
        begin_txn();
        xfer(8'h7F, c[0]); xfer(8'h01, c[1]); xfer(8'h02, c[2]);
        end_txn();
        checks++;
        if ({c[1], c[2]} !== 16'hFFFF) $display("FAIL ignore tx: got %h %h expected ff ff", c[1], c[2]);
        else passes++;
        checks++;
        if (req_cycles !== rc) $display("FAIL ignore req: got %0d request cycles expected 0", req_cycles - rc);
        else passes++;
    endtask

    task automatic test_cs_abort();
        logic [7:0]  tx;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = a ^ 16'h8000;
        mem_m[b] = 8'($urandom);
        ack_lat = 20;
        begin_txn();
        checks++;
        if (tx_data !== 8'h00) $display("FAIL abort cmd_entry tx: got %h expected 00", tx_data);
        else passes++;
        xfer(8'h02, tx); xfer(a[15:8], tx); xfer(a[7:0], tx);
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b11) $display("FAIL abort held: got req=%b busy=%b expected 1 1", mem_req, busy);
        else passes++;
        for (int i = 0; i < 100 && mem_req; i++) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) $display("FAIL abort ack_wait: got req=%b expected 0", mem_req);
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL abort idle: got busy=%b expected 0", busy);
        else passes++;
        ack_lat = 1;
        begin_txn();
        xfer(8'h02, tx); xfer(b[15:8], tx); xfer(b[7:0], tx); xfer(8'h00, tx);
        end_txn();
        checks++;
        if (tx !== mem_m[b]) $display("FAIL abort next_read: got %h expected %h", tx, mem_m[b]);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] tx, r1, r2;
        hold_ack = 1'b1;
        ack_lat = 0;
        begin_txn();
        xfer(8'h01, tx); xfer(8'h56, tx); xfer(8'h78, tx); xfer(8'h9C, tx);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h5678, 8'h9C})
            $display("FAIL reset_mid pre: got req=%b we=%b addr=%h wdata=%h expected 1 1 5678 9c",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else passes++;
        @(negedge clk);
        rst = 1'b1;
        spi_cs = 1'b1;
        #1;
        checks++;
        if ({tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy} !== 35'd0)
            $display("FAIL reset_mid outputs: got tx=%h req=%b we=%b addr=%h wdata=%h busy=%b expected all 0",
                     tx_data, mem_req, mem_we, mem_addr, mem_wdata, busy);
        else passes++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_ack = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b00) $display("FAIL reset_mid after: got req=%b busy=%b expected 0 0", mem_req, busy);
        else passes++;
        status_txn(r1, r2);
        checks++;
        if (r1 !== 8'h00) $display("FAIL reset_mid status: got %h expected 00", r1);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_write_fixed();
        test_read_wrap();
        test_random_rw();
        test_underrun();
        test_overrun();
        test_ignore();
        test_cs_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
